// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing constants for the register file
package regfile_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int NUM_REGS   = 32;
   localparam int ZERO_REG   = 31;
   localparam int ADDR_WIDTH = $clog2(NUM_REGS);
endpackage

// File: rtl/regfile_if.sv
// regfile_if: write port and two read ports of the register file
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int WIDTH  = DATA_WIDTH,
   parameter int ADDR_W = ADDR_WIDTH
);
   logic              RegWrite;
   logic [ADDR_W-1:0] WriteRegister;
   logic [WIDTH-1:0]  WriteData;
   logic [ADDR_W-1:0] ReadRegister1;
   logic [ADDR_W-1:0] ReadRegister2;
   logic [WIDTH-1:0]  ReadData1;
   logic [WIDTH-1:0]  ReadData2;
   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2
   );
   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/regfile_readmux.sv
// regfile_readmux: DEPTH:1 binary mux tree, address bit 0 selects at the leaves
module regfile_readmux
   import regfile_pkg::*;
#(
   parameter int WIDTH = DATA_WIDTH,
   parameter int DEPTH = NUM_REGS,
   localparam int AW   = $clog2(DEPTH),
   localparam int N    = 1 << AW
) (
   input  logic [AW-1:0]    sel_i,
   input  logic [WIDTH-1:0] data_i [DEPTH],
   output logic [WIDTH-1:0] data_o
);
   logic [WIDTH-1:0] tree [N];
   // fold pairs level by level: level l halves the candidates using sel_i[l]
   always_comb begin
      for (int i = 0; i < N; i++) begin
         if (i < DEPTH) tree[i] = data_i[i];
         else tree[i] = '0;
      end
      for (int l = 0; l < AW; l++)
         for (int k = 0; k < (N >> (l + 1)); k++)
            tree[k] = sel_i[l] ? tree[2 * k + 1] : tree[2 * k];
      data_o = tree[0];
   end
endmodule

// File: rtl/regfile.sv
// regfile: NUM_REGS x DATA_WIDTH register file, one write port, two combinational read ports
module regfile
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = regfile_pkg::NUM_REGS,
   parameter int ZERO_REG   = regfile_pkg::ZERO_REG
) (
   input logic clk,
   input logic reset_n,
   regfile_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);
   logic [NUM_REGS-1:0]   wr_en;
   logic [DATA_WIDTH-1:0] regs_d  [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_q  [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_vals [NUM_REGS];
   // one-hot write enable; the zero register never gets an enable
   always_comb begin
      wr_en = '0;
      for (int i = 0; i < NUM_REGS; i++)
         wr_en[i] = bus.RegWrite && (bus.WriteRegister == AW'(i)) && (i != ZERO_REG);
   end
   // enabled D inputs: selected register loads write data, others hold
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++)
         regs_d[i] = wr_en[i] ? bus.WriteData : regs_q[i];
   end
   // register array with synchronous active-low clear that overrides writes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end
   // read view: the zero register is hardwired rather than taken from its flop
   always_comb begin
      for (int i = 0; i < NUM_REGS; i++)
         rd_vals[i] = (i == ZERO_REG) ? '0 : regs_q[i];
   end
   regfile_readmux #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_REGS)) u_rd1 (
      .sel_i  (bus.ReadRegister1),
      .data_i (rd_vals),
      .data_o (bus.ReadData1)
   );
   regfile_readmux #(.WIDTH(DATA_WIDTH), .DEPTH(NUM_REGS)) u_rd2 (
      .sel_i  (bus.ReadRegister2),
      .data_i (rd_vals),
      .data_o (bus.ReadData2)
   );
endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed and random checks of regfile against an array model
module tb_regfile;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [63:0] model [32];
   int n_checks = 0;
   int n_fail = 0;

   regfile_if bus ();

   regfile dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] expect_rd(input int a);
      return (a == 31) ? 64'h0 : model[a];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_pair(input string tag, input int a1, input int a2);
      bus.ReadRegister1 = 5'(a1);
      bus.ReadRegister2 = 5'(a2);
      #1;
      check($sformatf("%s rd1[%0d]", tag, a1), bus.ReadData1, expect_rd(a1));
      check($sformatf("%s rd2[%0d]", tag, a2), bus.ReadData2, expect_rd(a2));
   endtask

   task automatic apply_edge(input logic we, input int wa, input logic [63:0] wd, input logic rst_n);
      bus.RegWrite = we;
      bus.WriteRegister = 5'(wa);
      bus.WriteData = wd;
      reset_n = rst_n;
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) model[i] = 64'h0;
      end else if (we && wa != 31) begin
         model[wa] = wd;
      end
      #1;
      bus.RegWrite = 1'b0;
      reset_n = 1'b1;
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) check_pair(tag, i, 31 - i);
   endtask

   initial begin
      bus.RegWrite = 1'b0;
      bus.WriteRegister = '0;
      bus.WriteData = '0;
      bus.ReadRegister1 = '0;
      bus.ReadRegister2 = '0;
      for (int i = 0; i < 32; i++) model[i] = 64'h0;

      apply_edge(1'b0, 0, 64'h0, 1'b0);
      sweep("reset");

      for (int i = 0; i < 31; i++) apply_edge(1'b1, i, 64'h100 + 64'(i), 1'b1);
      for (int i = 0; i < 32; i++) check_pair("write_all", i, i);
      for (int i = 0; i < 31; i++) check($sformatf("write_all const[%0d]", i), expect_rd(i), 64'h100 + 64'(i));

      apply_edge(1'b1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      check_pair("zero_reg", 31, 31);
      check("zero_reg const", bus.ReadData1, 64'h0);

      apply_edge(1'b0, 5, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
      check_pair("enable_low", 5, 5);
      check("enable_low const", bus.ReadData1, 64'h105);

      apply_edge(1'b1, 7, 64'h1, 1'b1);
      bus.RegWrite = 1'b1;
      bus.WriteRegister = 5'd7;
      bus.WriteData = 64'h2;
      bus.ReadRegister1 = 5'd7;
      bus.ReadRegister2 = 5'd7;
      #1;
      check("same_cycle before", bus.ReadData1, 64'h1);
      check("same_cycle before rd2", bus.ReadData2, 64'h1);
      @(posedge clk);
      #1;
      bus.RegWrite = 1'b0;
      check("same_cycle after", bus.ReadData1, 64'h2);
      model[7] = 64'h2;

      apply_edge(1'b1, 3, 64'h55, 1'b1);
      check_pair("pre_reset", 3, 3);
      apply_edge(1'b1, 3, 64'hAA, 1'b0);
      check_pair("reset_vs_write", 3, 3);
      check("reset_vs_write const", bus.ReadData1, 64'h0);
      sweep("reset_vs_write all");

      for (int n = 0; n < 300; n++) begin
         logic we;
         logic rst_n;
         int wa;
         int a1;
         int a2;
         logic [63:0] wd;
         we = 1'($urandom_range(0, 1));
         rst_n = ($urandom_range(0, 24) != 0);
         wa = $urandom_range(0, 31);
         a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
         a2 = $urandom_range(0, 31);
         wd = {$urandom, $urandom};
         bus.RegWrite = we;
         bus.WriteRegister = 5'(wa);
         bus.WriteData = wd;
         reset_n = rst_n;
         bus.ReadRegister1 = 5'(a1);
         bus.ReadRegister2 = 5'(a2);
         #1;
         check("rand pre rd1", bus.ReadData1, expect_rd(a1));
         check("rand pre rd2", bus.ReadData2, expect_rd(a2));
         @(posedge clk);
         if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
         end else if (we && wa != 31) begin
            model[wa] = wd;
         end
         #1;
         bus.RegWrite = 1'b0;
         reset_n = 1'b1;
         check("rand post rd1", bus.ReadData1, expect_rd(a1));
         check("rand post rd2", bus.ReadData2, expect_rd(a2));
      end
      sweep("rand final");

      apply_edge(1'b0, 0, 64'h0, 1'b0);
      for (int i = 0; i < 32; i++) begin
         bus.ReadRegister1 = 5'(i);
         bus.ReadRegister2 = 5'(i);
         #1;
         check($sformatf("final_reset rd1[%0d]", i), bus.ReadData1, 64'h0);
         check($sformatf("final_reset rd2[%0d]", i), bus.ReadData2, 64'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 Parameter DATA_WIDTH, default 64: width of each register and data port.
REQ-002 Parameter NUM_REGS, default 32: register count; address width = $clog2(NUM_REGS) = 5.
REQ-003 Parameter ZERO_REG, default 31: index of the hardwired-zero register.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset_n  input  1: synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 RegWrite  input  1: write enable for the write port.
REQ-007 WriteRegister  input  5: write address.
REQ-008 WriteData  input  DATA_WIDTH: write data.
REQ-009 ReadRegister1  input  5: read port 1 address.
REQ-010 ReadRegister2  input  5: read port 2 address.
REQ-011 ReadData1  output  DATA_WIDTH: read port 1 data.
REQ-012 ReadData2  output  DATA_WIDTH: read port 2 data.

Function
REQ-013 Storage SHALL be NUM_REGS registers of DATA_WIDTH bits, one clk domain.
REQ-014 Write: on a rising edge with reset_n=1 and RegWrite=1, register[WriteRegister] SHALL load WriteData; no other register changes.
REQ-015 RegWrite=0: no register SHALL change.
REQ-016 Write to ZERO_REG SHALL be discarded; register ZERO_REG reads 0 at all times.
REQ-017 Reads SHALL be combinational, 0-cycle latency: ReadDataN = register[ReadRegisterN] in the same cycle the address is applied.
REQ-018 Both read ports SHALL be independent; same address on both ports returns identical data.
REQ-019 Read and write of the same address in one cycle: read SHALL return the old value until the edge, new value after it (no write-through bypass).
REQ-020 Write data SHALL be stored exactly; no sign-extension, truncation or arithmetic.
REQ-021 Each read port SHALL select via a mux tree: log2(NUM_REGS) levels of 2:1 selection, address bit 0 at the leaf level.
REQ-022 Write decode SHALL be one-hot over NUM_REGS, gated by RegWrite; at most one register enable active per cycle.

Reset
REQ-023 On a rising edge with reset_n=0, every register SHALL become 0, overriding any concurrent write.
REQ-024 After reset, ReadData1 and ReadData2 SHALL be 0 for every address.
REQ-025 Reset asserted mid-sequence SHALL discard the in-flight write of that cycle; no partial state retained.
REQ-026 No asynchronous path from reset_n to state; deassertion takes effect at next rising edge.

Structure
REQ-027 Shared package regfile_pkg SHALL hold DATA_WIDTH, NUM_REGS, ZERO_REG and the address-width constant.
REQ-028 One sub-module, regfile_readmux (NUM_REGS:1 by DATA_WIDTH mux tree), SHALL be instantiated once per read port.
REQ-029 Write decoder and register array SHALL live in regfile itself; registers as enabled D flip-flops.

Verification
REQ-030 Reset: reset_n=0 one edge after random writes -> all 32 addresses read 0 on both ports.
REQ-031 Write/read all: write 64'h0000_0000_0000_0100 + i to reg i, i=0..30 -> read back reg i = 0x100+i on both ports, no aliasing.
REQ-032 Zero register: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF -> ReadData1(addr 31) = 0.
REQ-033 Enable low: RegWrite=0, WriteRegister=5, WriteData=64'hDEAD_BEEF_DEAD_BEEF -> reg 5 keeps its prior value.
REQ-034 Same-cycle read/write: reg 7 = 0x1, write 0x2 to reg 7 with ReadRegister1=7 -> ReadData1=0x1 before edge, 0x2 after.
REQ-035 Reset vs write: reset_n=0 and RegWrite=1, WriteRegister=3, WriteData=0xAA same edge -> reg 3 reads 0.
